// File: rtl/mano_timing_decoder.sv
// Timing and decode generator for the basic computer.
// Holds the start/stop flip-flop, the sequence counter, the instruction
// register, and the latched opcode decode (D) and indirect bit (J) that
// the per-register control blocks consume.
module mano_timing_decoder #(
  parameter int WORD_WIDTH = 16,
  parameter int SC_WIDTH   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     hlt,
  input  logic                     sc_clr,
  input  logic [WORD_WIDTH-1:0]    bus_in,
  output logic                     run,
  output logic [SC_WIDTH-1:0]      sc,
  output logic [2**SC_WIDTH-1:0]   T,
  output logic [7:0]               D,
  output logic                     J,
  output logic [WORD_WIDTH-1:0]    ir
);

  logic                  s_q;
  logic [SC_WIDTH-1:0]   sc_q;
  logic [WORD_WIDTH-1:0] ir_q;
  logic [7:0]            d_q;
  logic                  j_q;
  logic                  load_ir;
  logic                  load_decode;

  // IR captures the bus at the end of T1, the decode at the end of T2;
  // both use S as it was before this edge, so a hlt in T1 still loads IR.
  assign load_ir     = s_q && (sc_q == SC_WIDTH'(1));
  assign load_decode = s_q && (sc_q == SC_WIDTH'(2));

  // Start/stop flip-flop: hlt wins over start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q <= 1'b0;
    end else if (hlt) begin
      s_q <= 1'b0;
    end else if (start) begin
      s_q <= 1'b1;
    end
  end

  // Sequence counter: clear has priority and works even while stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_q <= '0;
    end else if (sc_clr) begin
      sc_q <= '0;
    end else if (s_q) begin
      sc_q <= sc_q + SC_WIDTH'(1);
    end
  end

  // Instruction register, loaded from the common bus at T1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q <= '0;
    end else if (load_ir) begin
      ir_q <= bus_in;
    end
  end

  // Opcode decode and indirect bit, latched at T2 and held until the next T2;
  // D resets to zero, which doubles as the "no opcode latched yet" state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 8'h00;
      j_q <= 1'b0;
    end else if (load_decode) begin
      d_q <= 8'd1 << ir_q[WORD_WIDTH-2 -: 3];
      j_q <= ir_q[WORD_WIDTH-1];
    end
  end

  // One-hot timing decode of the current count.
  always_comb begin
    T = '0;
    T[sc_q] = 1'b1;
  end

  assign run = s_q;
  assign sc  = sc_q;
  assign D   = d_q;
  assign J   = j_q;
  assign ir  = ir_q;

endmodule

// File: tb/tb_mano_timing_decoder.sv
// Self-checking bench for mano_timing_decoder: a cycle-level model of the
// timing rules is compared against the DUT on every falling edge, and
// directed scenarios add hand-computed literal checks.
module tb_mano_timing_decoder;

  localparam int WW = 16;
  localparam int SW = 3;

  logic          clk;
  logic          rst;
  logic          start;
  logic          hlt;
  logic          sc_clr;
  logic [WW-1:0] bus_in;
  logic          run;
  logic [SW-1:0] sc;
  logic [7:0]    T;
  logic [7:0]    D;
  logic          J;
  logic [WW-1:0] ir;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model state
  bit          m_run;
  int          m_sc;
  logic [15:0] m_ir;
  int          m_op;
  bit          m_j;
  bit          m_valid;

  mano_timing_decoder #(.WORD_WIDTH(WW), .SC_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .hlt(hlt), .sc_clr(sc_clr),
    .bus_in(bus_in), .run(run), .sc(sc), .T(T), .D(D), .J(J), .ir(ir)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: apply the rules using values as they were before the edge.
  always @(posedge clk or posedge rst) begin
    bit          old_run;
    int          old_sc;
    logic [15:0] old_ir;
    if (rst) begin
      m_run = 0; m_sc = 0; m_ir = '0; m_op = 0; m_j = 0; m_valid = 0;
    end else begin
      old_run = m_run;
      old_sc  = m_sc;
      old_ir  = m_ir;
      if (old_run && old_sc == 1) m_ir = bus_in;
      if (old_run && old_sc == 2) begin
        m_op    = int'(old_ir[14:12]);
        m_j     = old_ir[15];
        m_valid = 1;
      end
      if (sc_clr) m_sc = 0;
      else if (old_run) m_sc = (old_sc + 1) % 8;
      if (hlt) m_run = 0;
      else if (start) m_run = 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Compare all outputs against the model on every falling edge.
  always @(negedge clk) begin
    logic [7:0] exp_d;
    exp_d = m_valid ? (8'd1 << m_op) : 8'h00;
    checkOutput("model_run", 32'(run), 32'(m_run));
    checkOutput("model_sc",  32'(sc),  32'(m_sc));
    checkOutput("model_T",   32'(T),   32'(8'd1 << m_sc));
    checkOutput("model_D",   32'(D),   32'(exp_d));
    checkOutput("model_J",   32'(J),   32'(m_j));
    checkOutput("model_ir",  32'(ir),  32'(m_ir));
  end

  // Drive inputs for exactly one rising edge, then drop the pulses.
  task automatic applyStimulus(input logic st, input logic ht, input logic clr,
                               input logic [WW-1:0] bus);
    start  = st;
    hlt    = ht;
    sc_clr = clr;
    bus_in = bus;
    @(posedge clk);
    #1;
    start  = 1'b0;
    hlt    = 1'b0;
    sc_clr = 1'b0;
  endtask

  task automatic idle(input int n, input logic [WW-1:0] bus);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, bus);
  endtask

  logic [7:0] walk [0:5];

  initial begin
    walk[0] = 8'h08; walk[1] = 8'h10; walk[2] = 8'h20;
    walk[3] = 8'h40; walk[4] = 8'h80; walk[5] = 8'h01;
    rst = 1'b1; start = 1'b0; hlt = 1'b0; sc_clr = 1'b0; bus_in = '0;
    #12;
    rst = 1'b0;

    // Asynchronous reset in the middle of a count
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    idle(5, 16'h0000);
    checkOutput("pre_reset_sc", 32'(sc), 32'd5);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_run", 32'(run), 32'd0);
    checkOutput("rst_sc",  32'(sc),  32'd0);
    checkOutput("rst_T",   32'(T),   32'h01);
    checkOutput("rst_D",   32'(D),   32'h00);
    checkOutput("rst_J",   32'(J),   32'd0);
    checkOutput("rst_ir",  32'(ir),  32'h0000);
    #1 rst = 1'b0;

    // First instruction: A123 -> opcode 2, indirect
    applyStimulus(1'b1, 1'b0, 1'b0, 16'hA123);
    checkOutput("i1_T0", 32'(T), 32'h01);
    idle(1, 16'hA123);
    checkOutput("i1_T1", 32'(T), 32'h02);
    idle(1, 16'hA123);
    checkOutput("i1_ir", 32'(ir), 32'hA123);
    checkOutput("i1_T2", 32'(T), 32'h04);
    idle(1, 16'hA123);
    checkOutput("i1_D", 32'(D), 32'h04);
    checkOutput("i1_J", 32'(J), 32'd1);
    checkOutput("walk_T", 32'(T), 32'(walk[0]));
    for (int k = 1; k < 6; k++) begin
      idle(1, 16'hA123);
      checkOutput("walk_T", 32'(T), 32'(walk[k]));
    end

    // Early end of instruction at T4
    idle(4, 16'hA123);
    checkOutput("clr_pre_T4", 32'(T), 32'h10);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hA123);
    checkOutput("clr_sc", 32'(sc), 32'd0);
    checkOutput("clr_T",  32'(T),  32'h01);
    checkOutput("clr_D",  32'(D),  32'h04);
    checkOutput("clr_J",  32'(J),  32'd1);

    // Second instruction 7800: old decode held through T2
    idle(1, 16'h7800);
    checkOutput("i2_T1_D", 32'(D), 32'h04);
    idle(1, 16'h7800);
    checkOutput("i2_T2_ir", 32'(ir), 32'h7800);
    checkOutput("i2_T2_D", 32'(D), 32'h04);
    checkOutput("i2_T2_J", 32'(J), 32'd1);
    idle(1, 16'h7800);
    checkOutput("i2_T3_D", 32'(D), 32'h80);
    checkOutput("i2_T3_J", 32'(J), 32'd0);

    // hlt+start together in T1
    idle(6, 16'h3C5A);
    checkOutput("hs_pre_T1", 32'(T), 32'h02);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h3C5A);
    checkOutput("hs_run", 32'(run), 32'd0);
    checkOutput("hs_ir",  32'(ir),  32'h3C5A);
    idle(5, 16'h0000);
    checkOutput("hs_frozen_sc", 32'(sc), 32'd2);
    checkOutput("hs_frozen_D",  32'(D),  32'h80);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("hs_clr_sc",  32'(sc),  32'd0);
    checkOutput("hs_clr_run", 32'(run), 32'd0);

    // Free run with wrap; IR reloads at the second T1
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h1234);
    idle(2, 16'h1234);
    checkOutput("fr_ir1", 32'(ir), 32'h1234);
    idle(1, 16'hBEEF);
    checkOutput("fr_D1", 32'(D), 32'h02);
    idle(5, 16'hBEEF);
    checkOutput("fr_wrap_sc", 32'(sc), 32'd0);
    checkOutput("fr_wrap_T",  32'(T),  32'h01);
    idle(2, 16'hBEEF);
    checkOutput("fr_ir2", 32'(ir), 32'hBEEF);

    // hlt alone, then sc_clr while stopped and while already zero
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    checkOutput("hlt_sc", 32'(sc), 32'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    checkOutput("clr_zero_sc", 32'(sc), 32'd0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mano_timing_decoder.md
Name: mano_timing_decoder

Overview:
- Generates the timing and decode signals consumed by the register control logic of the basic computer: timing one-hot T[7:0], opcode one-hot D[7:0], and indirect bit J.
- Contains:
  - the start/stop flip-flop S;
  - the 3-bit sequence counter SC;
  - the instruction register IR, loaded from the common bus at T1;
  - the opcode/indirect latch, updated at T2.
- Sits between the common bus/memory and the per-register control blocks (AR, PC, DR, AC, ...).

Parameters:
- WORD_WIDTH, 16, width of the common bus and IR. Must be ≥ 4. The opcode is IR[WORD_WIDTH-2 : WORD_WIDTH-4]; the indirect bit is IR[WORD_WIDTH-1].
- SC_WIDTH, 3, sequence counter width. T width = 2**SC_WIDTH (8 at default).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; sets S.
- hlt  in  1  single-cycle pulse; clears S. Has priority over start.
- sc_clr  in  1  from control logic; clears SC at the next edge (end of instruction).
- bus_in  in  WORD_WIDTH  common bus value; holds the instruction word during T1.
- run  out  1  current value of S.
- sc  out  SC_WIDTH  current sequence count.
- T  out  2**SC_WIDTH  one-hot decode of sc.
- D  out  8  one-hot decode of the latched opcode.
- J  out  1  latched indirect bit.
- ir  out  WORD_WIDTH  instruction register contents.

Behaviour:
- Reset (async, immediate, any cycle including mid-instruction):
  - S=0, SC=0, IR=0, opcode latch=0, J=0.
  - Outputs: run=0, sc=0, T=8'h01, D=8'h00 (D is gated by a valid flag, which resets to 0), J=0, ir=0.
- S flip-flop, per edge:
  - if hlt: S←0
  - else if start: S←1
  - else S holds.
- SC, per edge, in priority order:
  - if sc_clr: SC←0. Applies even when run=0.
  - else if S=1: SC←SC+1, wrapping 7→0 with no flag.
  - else SC holds.
- T output: combinational. T[k]=1 iff sc==k; exactly one bit set at all times.
- IR: on an edge where S=1 and T[1]=1, IR←bus_in. Otherwise IR holds. A sc_clr in the same cycle does not block the load.
- Opcode/indirect latch: on an edge where S=1 and T[2]=1:
  - opcode ← IR[WORD_WIDTH-2 : WORD_WIDTH-4];
  - J ← IR[WORD_WIDTH-1];
  - valid ← 1.
- D output: registered decode. D[n]=valid & (opcode==n). D and J are stable from T3 of the current instruction until T3 of the next.
- Latency:
  - instruction on the bus in T1 → IR valid in T2;
  - D/J valid in T3.
- When S=0: IR and the opcode latch freeze and SC freezes, except that sc_clr still clears it. T continues to reflect the frozen SC.
- Simultaneous events:
  - hlt+start in one cycle: S=0.
  - hlt in T1: the edge ending T1 still loads IR (S is sampled before update); SC then freezes at 2.
  - sc_clr while SC=0: SC remains 0.

Test Plan:
- Reset with rst=1 mid-count (sc=5) → immediately run=0, sc=0, T=8'h01, D=8'h00, J=0, ir=16'h0000.
- Pulse start, hold bus_in=16'hA123 during T1, sc_clr=0 → ir=16'hA123 from T2; at T3 D=8'h04 (opcode 2), J=1; T walks 01,02,04,08,10,20,40,80,01.
- Set start, run to T4, assert sc_clr for one cycle → next cycle sc=0, T=8'h01; D/J unchanged (8'h04, 1) until the next T3.
- bus_in=16'h7800 for a second instruction → at T3 D=8'h80, J=0. The previous D is held through T2 of this instruction.
- At T1, assert hlt and start together → run=0; ir still loads bus_in; sc freezes at 2 across 5 idle cycles; a later sc_clr → sc=0 while run=0.
- Free-run with no sc_clr for 9 cycles from sc=0 → sc wraps 7→0 and T=8'h01 at cycle 8. IR reloads at the second T1.
